// File: rtl/instr_fetch.sv
// MSP430 fetch sequencer: walks the fetch PC through program ROM, sizes each
// instruction from its opcode and hands the complete bundle to the decoder.
module instr_fetch #(
    parameter logic [15:0] PC_RESET = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    output logic        rom_rd,
    input  logic [15:0] rom_data,
    input  logic        rom_ack,
    output logic [15:0] ir,
    output logic [15:0] ext_src,
    output logic [15:0] ext_dst,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic [15:0] next_pc,
    output logic        illegal,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [15:0] br_target,
    output logic [15:0] pc_out
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_SRC  = 2'd1,
        S_DST  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] pc;
    logic         dst_ext_q;

    logic         src_ext_w;
    logic         dst_ext_w;
    logic         illegal_w;
    logic [1:0]   len_w;
    logic         fmt1;
    logic         fmt2;
    logic         jmp;
    logic         reti;

    // Source operand needs an extension word: indexed/symbolic/absolute or #imm,
    // except where the constant generator (R3, or R2 with @Rn+) supplies it.
    function automatic logic src_needs_ext(input logic [1:0] as_f, input logic [3:0] sa);
        return ((as_f == 2'b01) && (sa != 4'd3)) || ((as_f == 2'b11) && (sa == 4'd0));
    endfunction

    // Opcode sizing on the word currently returned by ROM
    always_comb begin
        src_ext_w = 1'b0;
        dst_ext_w = 1'b0;
        illegal_w = 1'b0;
        fmt1      = (rom_data[15:12] >= 4'd4);
        fmt2      = (rom_data[15:10] == 6'b000100);
        jmp       = (rom_data[15:13] == 3'b001);
        reti      = (rom_data[15:7] == 9'b000100110);
        if (fmt1) begin
            src_ext_w = src_needs_ext(rom_data[5:4], rom_data[11:8]);
            dst_ext_w = rom_data[7];
        end else if (fmt2) begin
            src_ext_w = !reti && src_needs_ext(rom_data[5:4], rom_data[3:0]);
        end else if (!jmp) begin
            illegal_w = 1'b1;
        end
        len_w = 2'd1 + 2'(src_ext_w) + 2'(dst_ext_w);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect overrides everything
    always_comb begin
        state_nxt = state;
        if (br_valid) begin
            state_nxt = S_OP;
        end else begin
            case (state)
                S_OP: begin
                    if (rom_ack) begin
                        if (src_ext_w) begin
                            state_nxt = S_SRC;
                        end else if (dst_ext_w) begin
                            state_nxt = S_DST;
                        end else begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_SRC: begin
                    if (rom_ack) begin
                        state_nxt = dst_ext_q ? S_DST : S_HOLD;
                    end
                end
                S_DST: begin
                    if (rom_ack) begin
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        state_nxt = S_OP;
                    end
                end
                default: state_nxt = S_OP;
            endcase
        end
    end

    // PC and bundle registers; acks are only honoured while a read is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_RESET & 16'hFFFE;
            ir          <= '0;
            ext_src     <= '0;
            ext_dst     <= '0;
            instr_len   <= '0;
            instr_pc    <= '0;
            next_pc     <= '0;
            illegal     <= 1'b0;
            instr_valid <= 1'b0;
            dst_ext_q   <= 1'b0;
        end else begin
            instr_valid <= (state_nxt == S_HOLD);
            if (br_valid) begin
                pc <= br_target & 16'hFFFE;
            end else if (rom_ack && (state != S_HOLD)) begin
                pc <= pc + 16'd2;
                case (state)
                    S_OP: begin
                        ir        <= rom_data;
                        instr_pc  <= pc;
                        instr_len <= len_w;
                        next_pc   <= pc + 16'({len_w, 1'b0});
                        illegal   <= illegal_w;
                        dst_ext_q <= dst_ext_w;
                        ext_src   <= '0;
                        ext_dst   <= '0;
                    end
                    S_SRC:   ext_src <= rom_data;
                    S_DST:   ext_dst <= rom_data;
                    default: ;
                endcase
            end
        end
    end

    // Read request follows the fetch states directly and is gated by reset
    assign rom_rd   = (state != S_HOLD) && !rst;
    assign rom_addr = pc;
    assign pc_out   = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of programmed instructions plus
// hand-written sequences for back-pressure, redirects, wait states and reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data;
    logic        rom_ack;
    logic [15:0] ir;
    logic [15:0] ext_src;
    logic [15:0] ext_dst;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] next_pc;
    logic        illegal;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic [15:0] br_target;
    logic [15:0] pc_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:32767];
    logic [3:0]  wait_states;
    logic [3:0]  wcnt;

    always #5 clk = ~clk;

    instr_fetch #(.PC_RESET(16'hC000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_data    (rom_data),
        .rom_ack     (rom_ack),
        .ir          (ir),
        .ext_src     (ext_src),
        .ext_dst     (ext_dst),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .next_pc     (next_pc),
        .illegal     (illegal),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .pc_out      (pc_out)
    );

    // ROM model: ack after wait_states cycles of a held request
    assign rom_data = mem[rom_addr[15:1]];
    assign rom_ack  = rom_rd && (wcnt >= wait_states);

    always_ff @(posedge clk) begin
        if (!rom_rd || rom_ack) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 4'd1;
        end
    end

    typedef struct {
        logic [15:0] op;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [1:0]  len;
        logic [15:0] esrc;
        logic [15:0] edst;
        logic        ill;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got timeout after %0d cycles expected instr_valid", n);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] exp_pc;
        int          n;

        vecs[0] = '{16'h4506, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{16'h40B2, 16'h1234, 16'h0200, 2'd3, 16'h1234, 16'h0200, 1'b0};
        vecs[2] = '{16'h4316, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h4336, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'h4392, 16'h0300, 16'h0000, 2'd2, 16'h0000, 16'h0300, 1'b0};
        vecs[5] = '{16'h1295, 16'hABCD, 16'h0000, 2'd2, 16'hABCD, 16'h0000, 1'b0};
        vecs[6] = '{16'h1300, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{16'h2000, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 2'd1, 16'h0000, 16'h0000, 1'b1};
        vecs[9] = '{16'h5592, 16'h1111, 16'h2222, 2'd3, 16'h1111, 16'h2222, 1'b0};

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        a = 16'hC000;
        for (int i = 0; i < 10; i++) begin
            mem[a[15:1]] = vecs[i].op;
            a = a + 16'd2;
            if (vecs[i].len >= 2'd2) begin
                mem[a[15:1]] = vecs[i].w1;
                a = a + 16'd2;
            end
            if (vecs[i].len == 2'd3) begin
                mem[a[15:1]] = vecs[i].w2;
                a = a + 16'd2;
            end
        end
        a = 16'hC020; mem[a[15:1]] = 16'h40B2;
        a = 16'hC022; mem[a[15:1]] = 16'h5555;
        a = 16'hD000; mem[a[15:1]] = 16'h4506;
        a = 16'hFFFE; mem[a[15:1]] = 16'h4506;

        rst         = 1'b1;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_target   = 16'h0000;
        wait_states = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_rd", 16'(rom_rd), 16'h0000);
        chk("rst_rom_addr", rom_addr, 16'hC000);
        chk("rst_pc_out", pc_out, 16'hC000);
        chk("rst_valid", 16'(instr_valid), 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_len", 16'(instr_len), 16'h0000);
        chk("rst_next_pc", next_pc, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);

        rst = 1'b0;
        #1;
        chk("rel_rom_rd", 16'(rom_rd), 16'h0001);
        chk("rel_rom_addr", rom_addr, 16'hC000);

        // Table-driven instruction stream, zero-wait ROM
        exp_pc = 16'hC000;
        for (int i = 0; i < 10; i++) begin
            wait_valid(n);
            chk($sformatf("v%0d_latency", i), 16'(n), 16'(vecs[i].len));
            chk($sformatf("v%0d_ir", i), ir, vecs[i].op);
            chk($sformatf("v%0d_len", i), 16'(instr_len), 16'(vecs[i].len));
            chk($sformatf("v%0d_ext_src", i), ext_src, vecs[i].esrc);
            chk($sformatf("v%0d_ext_dst", i), ext_dst, vecs[i].edst);
            chk($sformatf("v%0d_illegal", i), 16'(illegal), 16'(vecs[i].ill));
            chk($sformatf("v%0d_instr_pc", i), instr_pc, exp_pc);
            chk($sformatf("v%0d_next_pc", i), next_pc, exp_pc + 16'(2 * int'(vecs[i].len)));
            if (i == 0) begin
                repeat (5) @(negedge clk);
                chk("bp_valid", 16'(instr_valid), 16'h0001);
                chk("bp_ir", ir, 16'h4506);
                chk("bp_next_pc", next_pc, 16'hC002);
                chk("bp_pc_out", pc_out, 16'hC002);
                chk("bp_rom_rd", 16'(rom_rd), 16'h0000);
            end
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            exp_pc = exp_pc + 16'(2 * int'(vecs[i].len));
            chk($sformatf("v%0d_hs_valid", i), 16'(instr_valid), 16'h0000);
            chk($sformatf("v%0d_hs_rom_rd", i), 16'(rom_rd), 16'h0001);
            chk($sformatf("v%0d_hs_rom_addr", i), rom_addr, exp_pc);
        end

        // Redirect while fetching the source extension, with a same-cycle ack
        chk("br_op_addr", rom_addr, 16'hC020);
        @(negedge clk);
        chk("br_src_addr", rom_addr, 16'hC022);
        br_valid  = 1'b1;
        br_target = 16'hD001;
        @(negedge clk);
        br_valid = 1'b0;
        chk("br_rom_addr", rom_addr, 16'hD000);
        chk("br_rom_rd", 16'(rom_rd), 16'h0001);
        chk("br_valid_low", 16'(instr_valid), 16'h0000);
        wait_valid(n);
        chk("br_latency", 16'(n), 16'h0001);
        chk("br_instr_pc", instr_pc, 16'hD000);
        chk("br_ir", ir, 16'h4506);
        chk("br_ext_src", ext_src, 16'h0000);

        // Redirect from hold to FFFE, then 3 ROM wait states and PC wrap
        wait_states = 4'd3;
        br_valid    = 1'b1;
        br_target   = 16'hFFFE;
        @(negedge clk);
        br_valid = 1'b0;
        chk("ws_valid_low", 16'(instr_valid), 16'h0000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws_addr%0d", k), rom_addr, 16'hFFFE);
            chk($sformatf("ws_ack%0d", k), 16'(rom_ack), 16'h0000);
            @(negedge clk);
        end
        chk("ws_ack_final", 16'(rom_ack), 16'h0001);
        @(negedge clk);
        chk("ws_valid", 16'(instr_valid), 16'h0001);
        chk("ws_instr_pc", instr_pc, 16'hFFFE);
        chk("ws_pc_out", pc_out, 16'h0000);
        chk("ws_next_pc", next_pc, 16'h0000);

        // Handshake coinciding with a redirect
        instr_ready = 1'b1;
        br_valid    = 1'b1;
        br_target   = 16'hC002;
        @(negedge clk);
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        chk("co_valid", 16'(instr_valid), 16'h0000);
        chk("co_rom_addr", rom_addr, 16'hC002);
        chk("co_rom_rd", 16'(rom_rd), 16'h0001);

        // Reset asserted in the middle of a stalled fetch
        @(negedge clk);
        chk("mr_rom_addr", rom_addr, 16'hC002);
        rst = 1'b1;
        #1;
        chk("mr_rom_rd", 16'(rom_rd), 16'h0000);
        chk("mr_pc_out", pc_out, 16'hC000);
        chk("mr_valid", 16'(instr_valid), 16'h0000);
        chk("mr_ir", ir, 16'h0000);
        chk("mr_len", 16'(instr_len), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
